// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: walks the RegFile read ports in even/odd pairs and streams every word out over valid/ready.
// Optional feature macro DUMP_CHECKSUM_EN adds a rotate-XOR checksum of the streamed words on port csum.
module regfile_dump_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2,
    output logic              readEn,
    input  logic [DATA_W-1:0] readOut1,
    input  logic [DATA_W-1:0] readOut2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, EMIT0, EMIT1, DONE} state_t;

    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST_ODD = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              read_en_q;
    logic              out_valid_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] buf1_q;
    logic [1:0]        lat_cnt_q;
    logic              xfer;

    assign xfer = out_valid_q && out_ready;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= ADDR_W'(1);
            out_addr_q  <= '0;
            out_data_q  <= '0;
            buf1_q      <= '0;
            lat_cnt_q   <= '0;
        end else if (en) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ISSUE;
                        busy_q    <= 1'b1;
                        rs1_q     <= '0;
                        rs2_q     <= ADDR_W'(1);
                        read_en_q <= 1'b1;
                        lat_cnt_q <= '0;
                    end
                end
                ISSUE: begin
                    // Addresses are held RD_LAT+1 cycles so the sampled read data belongs to them.
                    if (lat_cnt_q == LAT_LAST) begin
                        out_data_q  <= readOut1;
                        buf1_q      <= readOut2;
                        out_addr_q  <= rs1_q;
                        out_valid_q <= 1'b1;
                        read_en_q   <= 1'b0;
                        state_q     <= EMIT0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                EMIT0: begin
                    if (xfer) begin
                        out_data_q <= buf1_q;
                        out_addr_q <= rs2_q;
                        state_q    <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        if (rs2_q == LAST_ODD) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rs1_q     <= rs1_q + ADDR_W'(2);
                            rs2_q     <= rs2_q + ADDR_W'(2);
                            read_en_q <= 1'b1;
                            lat_cnt_q <= '0;
                            state_q   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign readEn    = read_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] csum_d;

    // NOTE: next-state gets a default first so no latch is inferred.
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) begin
            csum_d = '0;
        end else if (xfer) begin
            csum_d = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ out_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (en) begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule
